// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the byte-addressable data memory.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    localparam int XLEN_DEF        = 64;
    localparam int DEPTH_BYTES_DEF = 256;
    localparam int ADDR_W_DEF      = 64;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed bytes of a stored word and sign/zero-extends them to XLEN.
module load_extend
    import data_mem_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  word_i,
    input  logic [OFF_W-1:0] off_i,
    input  size_e            size_i,
    input  logic             uns_i,
    output logic [XLEN-1:0]  data_o
);

    logic [XLEN-1:0] shifted;

    // Lane select by right shift, then extension from the access width.
    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        data_o  = shifted;
        case (size_i)
            SZ_B: data_o = uns_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SZ_H: data_o = uns_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            SZ_W: data_o = uns_i ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            SZ_D: data_o = shifted;
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressable data memory with sized loads/stores, a clear-on-reset sweep
// and a single-cycle registered response.
module data_mem_sized
    import data_mem_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int WORDS = DEPTH_BYTES / NB;
    localparam int PTR_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int AW1   = ADDR_W + 1;

    logic [7:0] mem [DEPTH_BYTES];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

    size_e             size;
    logic [3:0]        nbytes;
    logic              misaligned;
    logic              out_of_range;
    logic              accept;
    logic              do_store;
    logic [PTR_W-1:0]  word_idx;
    logic [OFF_W-1:0]  off;
    logic [NB-1:0]     wr_be;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   ld_data;

    // Request decode: alignment and range checks (range uses one extra bit so no wrap).
    always_comb begin
        size         = size_e'(req_size);
        nbytes       = 4'd1 << req_size;
        off          = req_addr[OFF_W-1:0];
        word_idx     = req_addr[IDX_W-1:OFF_W];
        misaligned   = |(off & OFF_W'(nbytes - 4'd1));
        out_of_range = ({1'b0, req_addr} + AW1'(nbytes)) > AW1'(DEPTH_BYTES);
        accept       = req_valid && (state_q == ST_IDLE);
        do_store     = accept && req_we && !misaligned && !out_of_range;
        wr_be        = NB'((16'd1 << nbytes) - 16'd1) << off;
        wr_data      = req_wdata << {off, 3'b000};
        for (int i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = mem[{word_idx, OFF_W'(i)}];
        end
    end

    load_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extend (
        .word_i (rd_word),
        .off_i  (off),
        .size_i (size),
        .uns_i  (req_unsigned),
        .data_o (ld_data)
    );

    // Next-state and response computation.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_INIT: begin
                clr_ptr_d = clr_ptr_q + PTR_W'(1);
                if (clr_ptr_q == PTR_W'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = misaligned || out_of_range;
                    if (req_we || misaligned || out_of_range) begin
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_rdata_d = ld_data;
                    end
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage writes: the INIT sweep clears a word per cycle, stores write enabled lanes.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int i = 0; i < NB; i++) begin
                mem[{clr_ptr_q, OFF_W'(i)}] <= 8'd0;
            end
        end else if (do_store) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[{word_idx, OFF_W'(i)}] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed self-checking bench for data_mem_sized with hand-computed expectations.
module tb_data_mem_sized;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;
    int cyc;

    data_mem_sized dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents one request, then checks its response one cycle later.
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic exp_err, input logic [63:0] exp_data);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({tag, "_err"},   {63'd0, rsp_err},   {63'd0, exp_err});
        chk({tag, "_data"},  rsp_rdata,          exp_data);
    endtask

    task automatic wait_init(input string tag);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (req_ready !== 1'b1 && cyc < 100);
        chk(tag, 64'(cyc), 64'd32);
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_err",   {63'd0, rsp_err},   64'd0);
        chk("rst_rdata", rsp_rdata,          64'd0);
        rst_n = 1'b1;
        wait_init("init_cycles");

        txn("ld0",    1'b0, 2'd3, 1'b0, 64'h00, 64'd0, 1'b0, 64'd0);
        txn("sd10",   1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 1'b0, 64'd0);
        txn("ld10",   1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0, 64'h1122334455667788);
        txn("lb10",   1'b0, 2'd0, 1'b0, 64'h10, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF88);
        txn("lbu10",  1'b0, 2'd0, 1'b1, 64'h10, 64'd0, 1'b0, 64'h88);
        txn("lh16",   1'b0, 2'd1, 1'b0, 64'h16, 64'd0, 1'b0, 64'h1122);
        txn("lh14",   1'b0, 2'd1, 1'b0, 64'h14, 64'd0, 1'b0, 64'h3344);
        txn("lw14",   1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 1'b0, 64'h11223344);
        txn("lb11",   1'b0, 2'd0, 1'b0, 64'h11, 64'd0, 1'b0, 64'h77);
        txn("sw12",   1'b1, 2'd2, 1'b0, 64'h12, 64'hAABBCCDD, 1'b1, 64'd0);
        txn("ld10b",  1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0, 64'h1122334455667788);
        txn("sw18",   1'b1, 2'd2, 1'b0, 64'h18, 64'hDEADBEEF8899AABB, 1'b0, 64'd0);
        txn("lw18",   1'b0, 2'd2, 1'b0, 64'h18, 64'd0, 1'b0, 64'hFFFFFFFF8899AABB);
        txn("lwu18",  1'b0, 2'd2, 1'b1, 64'h18, 64'd0, 1'b0, 64'h8899AABB);
        txn("lhu1a",  1'b0, 2'd1, 1'b1, 64'h1A, 64'd0, 1'b0, 64'h8899);
        txn("lh1a",   1'b0, 2'd1, 1'b0, 64'h1A, 64'd0, 1'b0, 64'hFFFFFFFFFFFF8899);
        txn("ld18",   1'b0, 2'd3, 1'b1, 64'h18, 64'd0, 1'b0, 64'h000000008899AABB);
        txn("ldf8",   1'b0, 2'd3, 1'b0, 64'hF8, 64'd0, 1'b0, 64'd0);
        txn("ld100",  1'b0, 2'd3, 1'b0, 64'h100, 64'd0, 1'b1, 64'd0);
        txn("lwfe",   1'b0, 2'd2, 1'b0, 64'hFE, 64'd0, 1'b1, 64'd0);
        txn("lwfc",   1'b0, 2'd2, 1'b0, 64'hFC, 64'd0, 1'b0, 64'd0);
        txn("lbff",   1'b0, 2'd0, 1'b0, 64'hFF, 64'd0, 1'b0, 64'd0);
        txn("ldhuge", 1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 1'b1, 64'd0);
        txn("sd100",  1'b1, 2'd3, 1'b0, 64'h100, 64'hCAFEF00DCAFEF00D, 1'b1, 64'd0);
        txn("sdhuge", 1'b1, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFF00, 64'hCAFEF00DCAFEF00D, 1'b1, 64'd0);
        txn("ld0b",   1'b0, 2'd3, 1'b0, 64'h00, 64'd0, 1'b0, 64'd0);

        // Store-looking inputs with req_valid low must not touch storage.
        req_we    = 1'b1;
        req_size  = 2'd3;
        req_addr  = 64'h10;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        chk("idle_novalid", {63'd0, rsp_valid}, 64'd0);
        txn("ld10c",  1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0, 64'h1122334455667788);

        @(negedge clk);
        #1;
        p0 = pulses;
        txn("sb20",   1'b1, 2'd0, 1'b0, 64'h20, 64'h123456789ABCDE5A, 1'b0, 64'd0);
        txn("lbu20",  1'b0, 2'd0, 1'b1, 64'h20, 64'd0, 1'b0, 64'h5A);
        @(negedge clk);
        #1;
        chk("pulse_end", {63'd0, rsp_valid}, 64'd0);
        chk("pulse_cnt", 64'(pulses - p0), 64'd2);
        txn("ld20",   1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b0, 64'h5A);

        // Reset during the response cycle of a load.
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_addr     = 64'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
        chk("pre_rst_data",  rsp_rdata, 64'h1122334455667788);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_data",  rsp_rdata, 64'd0);
        chk("async_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit_cycles");
        txn("ld10rst", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0, 64'd0);
        txn("lbu20rst", 1'b0, 2'd0, 1'b1, 64'h20, 64'd0, 1'b0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 Parameter XLEN, default 64: data width in bits; SHALL be 64, the supported value.
REQ-002 Parameter DEPTH_BYTES, default 256: storage size in bytes; SHALL be a power of two and a multiple of XLEN/8.
REQ-003 Parameter ADDR_W, default 64: request address width in bits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low. Ports are listed below, clock and reset first.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present this cycle.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored on stores.
REQ-012 req_addr  input  ADDR_W  byte address.
REQ-013 req_wdata  input  XLEN  store data; the low 8<<req_size bits are written.
REQ-014 rsp_valid  output  1  one-cycle response pulse.
REQ-015 rsp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  access was misaligned or out of range; qualified by rsp_valid.

Function
REQ-017 States: INIT (clear storage) and IDLE (serve requests); there are no other states.
REQ-018 INIT: the block SHALL write zero to one XLEN-wide word per cycle, in ascending order, for DEPTH_BYTES/(XLEN/8) cycles, then enter IDLE; req_ready = 0 throughout INIT.
REQ-019 IDLE: req_ready = 1 every cycle; a request is accepted on any rising edge where req_valid && req_ready.
REQ-020 Latency: rsp_valid SHALL pulse high for exactly one cycle, in the cycle after acceptance; one response per accepted request; back-to-back requests sustain one request per cycle.
REQ-021 Byte order is little-endian: byte addr+i holds bits [8i+7:8i] of the datum.
REQ-022 Misaligned access: when req_addr mod (1<<req_size) != 0, the response SHALL have rsp_err = 1 and rsp_rdata = 0, and storage is unchanged.
REQ-023 Out-of-range access: when req_addr + (1<<req_size) > DEPTH_BYTES, the behaviour SHALL be the same as REQ-022; no address wrap-around is permitted.
REQ-024 Store: the selected bytes SHALL be written on the accepting edge, other bytes are untouched, and the response carries rsp_err = 0 and rsp_rdata = 0.
REQ-025 Load: data SHALL be sampled on the accepting edge and extended to XLEN per req_size and req_unsigned; a double-size load ignores req_unsigned.
REQ-026 A load accepted the cycle after a store to overlapping bytes SHALL return the newly stored bytes.
REQ-027 Input values are don't-care when req_valid = 0 or req_ready = 0, and SHALL cause no state change.

Reset
REQ-028 While rst_n = 0: state = INIT, clear pointer = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 Reset asserted mid-operation SHALL drop any pending response and restart the full clear sequence after release.

Structure
REQ-030 Package data_mem_pkg SHALL hold the access-size enum (SZ_B, SZ_H, SZ_W, SZ_D), the state enum (ST_INIT, ST_IDLE) and the default parameter constants.
REQ-031 Sub-module load_extend (combinational) SHALL perform byte-lane select and sign/zero extension; the alignment/range check and the FSM stay in the top level.
REQ-032 Storage SHALL be a byte array of DEPTH_BYTES entries; it has no reset of its own and is cleared only by INIT.

Verification
REQ-033 Release reset with the default parameters -> req_ready rises after exactly 32 cycles; LD at 0x00 -> rsp_rdata = 0.
REQ-034 SD 0x1122334455667788 at 0x10, then LD 0x10 -> 0x1122334455667788; LB 0x10 -> 0xFFFFFFFFFFFFFF88; LBU 0x10 -> 0x88; LH 0x16 -> 0x1122.
REQ-035 SW 0xAABBCCDD at 0x12 (misaligned) -> rsp_err = 1; a following LD 0x10 still returns 0x1122334455667788.
REQ-036 LD 0xF8 -> rsp_err = 0; LD 0x100 and LW 0xFE -> rsp_err = 1 and rsp_rdata = 0.
REQ-037 SB 0x5A at 0x20 immediately followed by LBU 0x20 -> 0x5A; check one rsp_valid pulse per request.
REQ-038 Assert rst_n = 0 during a load-response cycle -> rsp_valid drops asynchronously; after release, 32 INIT cycles follow and LD 0x10 -> 0.
